// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial (UART) blocks.
// The PARITY state exists only when SERIAL_OUTPUT_TX_PARITY_EN is defined.
package serial_pkg;

    localparam int FRAME_DATA_BITS = 8;

`ifdef SERIAL_OUTPUT_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Free-running bit-period counter: counts 0..CLOCKS_PER_BIT-1 and pulses tick on the last count.
// Held at zero while clear is high so a new bit period starts cleanly.
module baud_tick_counter #(
    parameter int CLOCKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int COUNT_WIDTH = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CLOCKS_PER_BIT - 1);

    logic [COUNT_WIDTH-1:0] count;

    assign tick = (count == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_output_tx.sv
// UART transmitter: accepts a 16-bit word on a stb/ack handshake and sends its low byte as 8N1.
// Define SERIAL_OUTPUT_TX_PARITY_EN to insert an even-parity bit (8E1).
module serial_output_tx
    import serial_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] input_in,
    input  logic        input_in_stb,
    output logic        input_in_ack,
    output logic        tx,
    output logic        busy
);

    localparam int         CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic [2:0] LAST_BIT       = 3'(FRAME_DATA_BITS - 1);

    state_t     state, state_next;
    logic [2:0] bit_index, bit_index_next;
    logic [7:0] data_byte, data_byte_next;
    logic       tx_next, ack_next, busy_next;
    logic       tick;
    logic       unused_upper_byte;

    assign unused_upper_byte = ^input_in[15:8];

    baud_tick_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // All outputs are registered so ack has no combinational path from stb and tx never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_index    <= '0;
            data_byte    <= '0;
            tx           <= 1'b1;
            input_in_ack <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            bit_index    <= bit_index_next;
            data_byte    <= data_byte_next;
            tx           <= tx_next;
            input_in_ack <= ack_next;
            busy         <= busy_next;
        end
    end

    always_comb begin
        state_next     = state;
        bit_index_next = bit_index;
        data_byte_next = data_byte;
        tx_next        = tx;
        ack_next       = input_in_ack;
        busy_next      = busy;
        case (state)
            IDLE: begin
                ack_next  = 1'b1;
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (input_in_stb && input_in_ack) begin
                    data_byte_next = input_in[7:0];
                    ack_next       = 1'b0;
                    busy_next      = 1'b1;
                    tx_next        = 1'b0;
                    bit_index_next = '0;
                    state_next     = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next     = DATA;
                    bit_index_next = '0;
                    tx_next        = data_byte[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_index == LAST_BIT) begin
`ifdef SERIAL_OUTPUT_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = ^data_byte;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_index_next = bit_index + 3'd1;
                        tx_next        = data_byte[bit_index + 3'd1];
                    end
                end
            end
`ifdef SERIAL_OUTPUT_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                    ack_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_output_tx.sv
// Directed self-checking bench for serial_output_tx at 16 clocks per bit.
// Expects the parity bit in each frame when SERIAL_OUTPUT_TX_PARITY_EN is defined.
module tb_serial_output_tx;

    localparam int CPB = 16;
`ifdef SERIAL_OUTPUT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] input_in;
    logic        input_in_stb;
    logic        input_in_ack;
    logic        tx;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int handshakes  = 0;
    int hs_base;

    serial_output_tx #(
        .CLOCK_FREQUENCY(16),
        .BAUD_RATE      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_in    (input_in),
        .input_in_stb(input_in_stb),
        .input_in_ack(input_in_ack),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Independent handshake count taken from the bus itself.
    always @(posedge clk) begin
        if (input_in_stb && input_in_ack) handshakes++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present a word and wait (bounded) for it to be taken; returns on the negedge
    // right after the transfer edge, i.e. the first start-bit cycle. stb is left high.
    task automatic applyStimulus(input logic [15:0] word, input string tag);
        input_in     = word;
        input_in_stb = 1'b1;
        for (int i = 0; i < 400 && input_in_ack !== 1'b1; i++) @(negedge clk);
        checkOutput({tag, "_ack_wait"}, input_in_ack, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Walk the frame one cycle at a time. pulse_at injects a one-cycle 0x00FF strobe;
    // stop_at returns early (at that cycle's negedge) without checking it.
    task automatic checkFrame(input logic [7:0] data, input string tag,
                              input int pulse_at, input int stop_at);
        logic exp_bit;
        int   b;
        for (int cyc = 0; cyc < FRAME_BITS * CPB; cyc++) begin
            if (cyc == stop_at) return;
            b = cyc / CPB;
            if (b == 0)                exp_bit = 1'b0;
            else if (b <= 8)           exp_bit = data[b-1];
`ifdef SERIAL_OUTPUT_TX_PARITY_EN
            else if (b == 9)           exp_bit = ^data;
`endif
            else                       exp_bit = 1'b1;
            checkOutput($sformatf("%s_tx_bit%0d_cyc%0d", tag, b, cyc), tx, exp_bit);
            if (cyc % CPB == 0) begin
                checkOutput($sformatf("%s_busy_bit%0d", tag, b), busy, 1'b1);
                checkOutput($sformatf("%s_ack_bit%0d", tag, b), input_in_ack, 1'b0);
            end
            if (cyc == pulse_at) begin
                input_in     = 16'h00FF;
                input_in_stb = 1'b1;
            end else if (pulse_at >= 0 && cyc == pulse_at + 1) begin
                input_in_stb = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_end_ack"}, input_in_ack, 1'b1);
        checkOutput({tag, "_end_busy"}, busy, 1'b0);
        checkOutput({tag, "_end_tx"}, tx, 1'b1);
    endtask

    initial begin
        rst          = 1'b1;
        input_in     = 16'h0000;
        input_in_stb = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_ack", input_in_ack, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_ack", input_in_ack, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            checkOutput("idle_tx", tx, 1'b1);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_ack", input_in_ack, 1'b1);
            @(negedge clk);
        end

        // Single frame; upper byte must be ignored.
        hs_base = handshakes;
        applyStimulus(16'h1255, "w1255");
        input_in_stb = 1'b0;
        checkFrame(8'h55, "w1255", -1, -1);
        checkCount("w1255_handshakes", handshakes, hs_base + 1);

        // Back-to-back with stb held high throughout.
        hs_base = handshakes;
        applyStimulus(16'h0041, "b2b_41");
        input_in = 16'h0042;
        checkFrame(8'h41, "b2b_41", -1, -1);
        applyStimulus(16'h0042, "b2b_42");
        input_in_stb = 1'b0;
        checkFrame(8'h42, "b2b_42", -1, -1);
        repeat (3) @(negedge clk);
        checkCount("b2b_handshakes", handshakes, hs_base + 2);

        // Strobe while busy (data bit 1) must be ignored, then accepted afterwards.
        hs_base = handshakes;
        applyStimulus(16'h0033, "busy_33");
        input_in_stb = 1'b0;
        checkFrame(8'h33, "busy_33", 40, -1);
        checkCount("busy_pulse_handshakes", handshakes, hs_base + 1);
        applyStimulus(16'h00FF, "late_ff");
        input_in_stb = 1'b0;
        checkFrame(8'hFF, "late_ff", -1, -1);
        checkCount("late_ff_handshakes", handshakes, hs_base + 2);

        // Reset in the middle of data bit 3 (a 0 bit) of 0xA5.
        hs_base = handshakes;
        applyStimulus(16'h00A5, "rst_a5");
        input_in_stb = 1'b0;
        checkFrame(8'hA5, "rst_a5", -1, 72);
        checkOutput("rst_a5_pre_tx", tx, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_async_tx", tx, 1'b1);
        checkOutput("rst_async_busy", busy, 1'b0);
        checkOutput("rst_async_ack", input_in_ack, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_release_ack", input_in_ack, 1'b1);
        checkOutput("rst_release_busy", busy, 1'b0);
        repeat (20) begin
            checkOutput("rst_no_replay_tx", tx, 1'b1);
            @(negedge clk);
        end
        checkCount("rst_handshakes", handshakes, hs_base + 1);
        applyStimulus(16'h003C, "post_rst_3c");
        input_in_stb = 1'b0;
        checkFrame(8'h3C, "post_rst_3c", -1, -1);

`ifdef SERIAL_OUTPUT_TX_PARITY_EN
        applyStimulus(16'h0007, "par_07");
        input_in_stb = 1'b0;
        checkFrame(8'h07, "par_07", -1, -1);
        applyStimulus(16'h0003, "par_03");
        input_in_stb = 1'b0;
        checkFrame(8'h03, "par_03", -1, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
